// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART Wishbone arbiter: FSM state encodings,
// watchdog counter width and a one-hot to index helper.
package uart_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int WDOG_CNT_W  = 16;
  localparam int MAX_MASTERS = 4;

  typedef logic [1:0] master_idx_t;

  // Position of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic master_idx_t onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    master_idx_t idx;
    idx = '0;
    for (int k = 0; k < MAX_MASTERS; k++) begin
      if (oh[k]) idx = master_idx_t'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational round-robin picker: searches the request vector starting
// one past the previous winner, wrapping, and returns a one-hot winner.
module uart_arb_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  master_idx_t            last_i,
  output logic [NUM_MASTERS-1:0] grant_o
);

  // First requester found after last_i in circular order wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    logic found;
    grant_o = '0;
    found   = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      int cand;
      cand = (int'(last_i) + i) % NUM_MASTERS;
      if (!found && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Round-robin Wishbone arbiter sharing one UART slave port among up to four
// masters. Grant is held for the owner's whole cyc; ack/err go to the owner.
// Optional watchdog enabled by defining UART_ARB_TIMEOUT_EN: terminates a
// stalled transfer with an err pulse and parks in FLUSH until cyc drops.
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADR_WIDTH      = 32,
  parameter int DAT_WIDTH      = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_MASTERS-1:0]             m_cyc_i,
  input  logic [NUM_MASTERS-1:0]             m_stb_i,
  input  logic [NUM_MASTERS-1:0]             m_we_i,
  input  logic [NUM_MASTERS*ADR_WIDTH-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DAT_WIDTH-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DAT_WIDTH/8-1:0] m_sel_i,
  output logic [NUM_MASTERS-1:0]             m_ack_o,
  output logic [NUM_MASTERS-1:0]             m_err_o,
  output logic [DAT_WIDTH-1:0]               m_dat_o,
  output logic                               s_cyc_o,
  output logic                               s_stb_o,
  output logic                               s_we_o,
  output logic [ADR_WIDTH-1:0]               s_adr_o,
  output logic [DAT_WIDTH-1:0]               s_dat_o,
  output logic [DAT_WIDTH/8-1:0]             s_sel_o,
  input  logic                               s_ack_i,
  input  logic                               s_err_i,
  input  logic [DAT_WIDTH-1:0]               s_dat_i,
  output logic [NUM_MASTERS-1:0]             grant_o,
  output logic                               busy_o
);

  localparam int SEL_WIDTH = DAT_WIDTH / 8;

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_masters
    $error("uart_bus_arbiter: NUM_MASTERS must be 2..4");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("uart_bus_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  logic [1:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] pick;
  master_idx_t            last_q, last_d;

  logic                   own_cyc, own_stb, own_we;
  logic [ADR_WIDTH-1:0]   own_adr;
  logic [DAT_WIDTH-1:0]   own_dat;
  logic [SEL_WIDTH-1:0]   own_sel;
  logic                   owning;
  logic                   timeout_hit;

  uart_arb_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_pick (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .grant_o(pick)
  );

  // AND-OR select of the granted master's bus signals (grant is one-hot).
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        own_cyc = own_cyc | m_cyc_i[k];
        own_stb = own_stb | m_stb_i[k];
        own_we  = own_we  | m_we_i[k];
        own_adr = own_adr | m_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
        own_dat = own_dat | m_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
        own_sel = own_sel | m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  // Slave side is live only in OWN; IDLE and FLUSH present an idle bus.
  assign owning  = (state_q == ST_OWN);
  assign s_cyc_o = owning & own_cyc;
  assign s_stb_o = owning & own_stb;
  assign s_we_o  = owning & own_we;
  assign s_adr_o = owning ? own_adr : '0;
  assign s_dat_o = owning ? own_dat : '0;
  assign s_sel_o = owning ? own_sel : '0;

  assign m_ack_o = owning ? (grant_q & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_err_o = owning ? (grant_q & {NUM_MASTERS{s_err_i | timeout_hit}}) : '0;
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);

`ifdef UART_ARB_TIMEOUT_EN
  logic [WDOG_CNT_W-1:0] wd_cnt_q;

  // Expiry yields to a real termination arriving in the same cycle.
  assign timeout_hit = owning && (wd_cnt_q == WDOG_CNT_W'(TIMEOUT_CYCLES))
                       && !s_ack_i && !s_err_i;

  // Watchdog counts strobed owner cycles that the slave leaves unterminated.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
    end else if (state_q == ST_IDLE || s_ack_i || s_err_i) begin
      wd_cnt_q <= '0;
    end else if (owning && s_stb_o) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic: arbitrate in IDLE, release when the owner drops cyc.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          state_d = ST_OWN;
          grant_d = pick;
          last_d  = onehot_to_idx(MAX_MASTERS'(pick));
        end
      end
      ST_OWN: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (timeout_hit) begin
          state_d = ST_FLUSH;
        end
      end
`ifdef UART_ARB_TIMEOUT_EN
      ST_FLUSH: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= master_idx_t'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Self-checking bench for uart_bus_arbiter: directed steps plus a randomized
// phase checked against an ownership/round-robin reference model.
// Watchdog steps are compiled when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [N*SW-1:0] m_sel_i;
  logic [N-1:0]    m_ack_o, m_err_o;
  logic [DW-1:0]   m_dat_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic            s_ack_i, s_err_i;
  logic [DW-1:0]   s_dat_i;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  uart_bus_arbiter #(
    .NUM_MASTERS(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_master(input int k, input logic cyc, input logic we,
                              input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    m_cyc_i[k]            = cyc;
    m_stb_i[k]            = cyc;
    m_we_i[k]             = we;
    m_adr_i[k*AW +: AW]   = adr;
    m_dat_i[k*DW +: DW]   = dat;
    m_sel_i[k*SW +: SW]   = '1;
  endtask

  task automatic release_master(input int k);
    m_cyc_i[k] = 1'b0;
    m_stb_i[k] = 1'b0;
  endtask

  // Time bound for the whole run.
  initial begin
    #500000;
    $display("FAIL tb_time_limit: observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [AW-1:0] radr [N];
    logic [DW-1:0] rdat [N];
    int            served [N];
    int            exp_own, mo, mlast, stall, nxt;

    rst_i = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;

    // Reset state
    repeat (3) tick();
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_s_cyc", s_cyc_o, 0);
    check("rst_m_ack", m_ack_o, 0);
    rst_i = 1'b0;
    tick();

    // Single write from master 0
    drive_master(0, 1'b1, 1'b1, 32'h10, 64'h41);
    #1;
    check("t2_no_grant_yet", grant_o, 0);
    tick();
    check("t2_grant", grant_o, 3'b001);
    check("t2_s_cyc", s_cyc_o, 1);
    check("t2_s_adr", s_adr_o, 32'h10);
    check("t2_s_dat", s_dat_o, 64'h41);
    check("t2_s_we", s_we_o, 1);
    check("t2_ack_early", m_ack_o, 0);
    s_ack_i = 1'b1; s_dat_i = 64'h55;
    #1;
    check("t2_m_ack", m_ack_o, 3'b001);
    check("t2_m_dat", m_dat_o, 64'h55);
    tick();
    s_ack_i = 1'b0;
    release_master(0);
    #1;
    check("t2_hold_grant", grant_o, 3'b001);
    check("t2_s_cyc_drop", s_cyc_o, 0);
    tick();
    check("t2_idle_grant", grant_o, 0);
    check("t2_idle_busy", busy_o, 0);

    // Master 1 owns, master 0 waits without seeing ack
    drive_master(1, 1'b1, 1'b0, 32'h20, 64'h0);
    tick();
    check("t3_grant_m1", grant_o, 3'b010);
    drive_master(0, 1'b1, 1'b1, 32'h30, 64'h77);
    for (int i = 0; i < 4; i++) begin
      s_ack_i = (i == 1);
      #1;
      check("t3_m0_no_ack", m_ack_o[0], 0);
      check("t3_grant_held", grant_o, 3'b010);
      check("t3_s_adr", s_adr_o, 32'h20);
      tick();
    end
    s_ack_i = 1'b0;
    release_master(1);
    tick();
    check("t3_gap", grant_o, 0);
    tick();
    check("t3_grant_m0", grant_o, 3'b001);
    check("t3_s_adr_m0", s_adr_o, 32'h30);
    release_master(0);
    tick();
    tick();

    // Masters 0 and 1 request continuously: alternating grants, one idle cycle between
    drive_master(0, 1'b1, 1'b0, 32'h40, 64'h0);
    drive_master(1, 1'b1, 1'b0, 32'h41, 64'h0);
    tick();
    exp_own = 1;
    for (int t = 0; t < 4; t++) begin
      check("t4_grant", grant_o, 64'(1) << exp_own);
      check("t4_s_adr", s_adr_o, 64'h40 + 64'(exp_own));
      s_ack_i = 1'b1;
      #1;
      check("t4_ack", m_ack_o, 64'(1) << exp_own);
      tick();
      s_ack_i = 1'b0;
      release_master(exp_own);
      #1;
      check("t4_s_cyc_drop", s_cyc_o, 0);
      tick();
      check("t4_gap_grant", grant_o, 0);
      check("t4_gap_s_cyc", s_cyc_o, 0);
      m_cyc_i[exp_own] = 1'b1;
      m_stb_i[exp_own] = 1'b1;
      tick();
      exp_own = 1 - exp_own;
    end
    check("t4_grant_last", grant_o, 64'(1) << exp_own);
    release_master(0);
    release_master(1);
    tick();
    tick();

    // Asynchronous reset mid-transfer
    drive_master(2, 1'b1, 1'b1, 32'h60, 64'h99);
    tick();
    check("t5_grant_m2", grant_o, 3'b100);
    drive_master(0, 1'b1, 1'b0, 32'h61, 64'h0);
    drive_master(1, 1'b1, 1'b0, 32'h62, 64'h0);
    s_ack_i = 1'b1;
    #1;
    rst_i = 1'b1;
    #1;
    check("t5_rst_s_cyc", s_cyc_o, 0);
    check("t5_rst_grant", grant_o, 0);
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_ack", m_ack_o, 0);
    s_ack_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    check("t5_no_grant_yet", grant_o, 0);
    tick();
    check("t5_first_m0", grant_o, 3'b001);
    release_master(0);
    release_master(1);
    release_master(2);
    tick();
    tick();

    // Randomized traffic against an ownership model (idle, last winner = 0)
    mo = -1; mlast = 0; stall = 0;
    for (int k = 0; k < N; k++) begin
      radr[k] = '0; rdat[k] = '0; served[k] = 0;
    end
    for (int c = 0; c < 700; c++) begin
      logic          a, e;
      logic [DW-1:0] sd;
      logic [N-1:0]  exp_g, done;
      if (c >= 450 && m_cyc_i == '0 && mo < 0) break;
      a = 1'b0; e = 1'b0;
      if (mo >= 0 && m_cyc_i[mo]) begin
        if (stall >= 3 || $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 7) == 0) e = 1'b1; else a = 1'b1;
          stall = 0;
        end else begin
          stall++;
        end
      end
      sd = {$urandom, $urandom};
      s_ack_i = a; s_err_i = e; s_dat_i = sd;
      #1;
      exp_g = '0;
      if (mo >= 0) exp_g[mo] = 1'b1;
      check("rnd_grant", grant_o, exp_g);
      check("rnd_busy", busy_o, mo >= 0);
      check("rnd_s_cyc", s_cyc_o, (mo >= 0) && m_cyc_i[mo]);
      check("rnd_s_adr", s_adr_o, (mo >= 0) ? radr[mo] : '0);
      check("rnd_s_dat", s_dat_o, (mo >= 0) ? rdat[mo] : '0);
      check("rnd_m_ack", m_ack_o, a ? exp_g : '0);
      check("rnd_m_err", m_err_o, e ? exp_g : '0);
      check("rnd_m_dat", m_dat_o, sd);
      done = '0;
      if (a || e) begin
        served[mo]++;
        done[mo] = 1'b1;
      end
      nxt = mo;
      if (mo < 0) begin
        for (int i = 1; i <= N; i++) begin
          int cand;
          cand = (mlast + i) % N;
          if (nxt < 0 && m_cyc_i[cand]) nxt = cand;
        end
        if (nxt >= 0) begin
          mlast = nxt;
          stall = 0;
        end
      end else if (!m_cyc_i[mo]) begin
        nxt = -1;
      end
      mo = nxt;
      tick();
      s_ack_i = 1'b0; s_err_i = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (done[k]) begin
          release_master(k);
        end else if (!m_cyc_i[k] && c < 450 && $urandom_range(0, 2) == 0) begin
          radr[k] = $urandom;
          rdat[k] = {$urandom, $urandom};
          drive_master(k, 1'b1, 1'($urandom_range(0, 1)), radr[k], rdat[k]);
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      check("rnd_served", served[k] > 0, 1);
    end
    tick();

`ifdef UART_ARB_TIMEOUT_EN
    // Slave never answers: err pulse after the 4th stalled cycle, then FLUSH
    drive_master(1, 1'b1, 1'b0, 32'h70, 64'h0);
    tick();
    check("wd_grant", grant_o, 3'b010);
    for (int i = 0; i < TO; i++) begin
      #1;
      check("wd_no_err_early", m_err_o, 0);
      check("wd_s_cyc", s_cyc_o, 1);
      tick();
    end
    #1;
    check("wd_err_pulse", m_err_o, 3'b010);
    check("wd_no_ack", m_ack_o, 0);
    tick();
    #1;
    check("wd_flush_cyc", s_cyc_o, 0);
    check("wd_flush_stb", s_stb_o, 0);
    check("wd_err_one_cycle", m_err_o, 0);
    check("wd_flush_busy", busy_o, 1);
    tick();
    #1;
    check("wd_flush_hold", s_cyc_o, 0);
    check("wd_flush_busy2", busy_o, 1);
    release_master(1);
    tick();
    check("wd_idle_busy", busy_o, 0);
    check("wd_idle_grant", grant_o, 0);

    // Ack arriving in the expiry cycle wins
    drive_master(1, 1'b1, 1'b0, 32'h71, 64'h0);
    tick();
    check("wd2_grant", grant_o, 3'b010);
    for (int i = 0; i < TO; i++) begin
      #1;
      check("wd2_no_err_early", m_err_o, 0);
      tick();
    end
    s_ack_i = 1'b1;
    #1;
    check("wd2_ack_wins", m_ack_o, 3'b010);
    check("wd2_no_err", m_err_o, 0);
    tick();
    s_ack_i = 1'b0;
    #1;
    check("wd2_stays_own", busy_o, 1);
    check("wd2_s_cyc", s_cyc_o, 1);
    check("wd2_cleared", m_err_o, 0);
    tick();
    #1;
    check("wd2_cleared2", m_err_o, 0);
    release_master(1);
    tick();
    tick();
    check("wd2_idle", busy_o, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
